mul4_fitness_scorer: RTL

- Downstream stage of each evolved 2x2-bit multiplier candidate.
- Consumes the candidate's bit-sliced operands (a1, a0, b1, b0) and outputs (y3..y0), 16 lanes per word.
- Computes the golden 2x2 product per lane and counts correct output bits over NUM_BATCHES words.
- Produces the fitness score used by the tournament selector.

---
 rtl/mul4_eval_pkg.sv | 30 +++
 rtl/mul4_fitness_scorer_popcount16.sv | 14 +
 rtl/mul4_fitness_scorer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared types and the golden 2x2-bit multiplier reference for the fitness scorer.
// Lanes are bit-sliced: lane i of every vector belongs to one candidate test case.
package mul4_eval_pkg;

    localparam int LANES    = 16;
    localparam int OUT_BITS = 4;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [LANES-1:0] g3;
        logic [LANES-1:0] g2;
        logic [LANES-1:0] g1;
        logic [LANES-1:0] g0;
    } golden_t;

    // Bitwise sum-of-products form of {a1,a0} * {b1,b0}, evaluated on all lanes at once.
    function automatic golden_t golden_2x2(input logic [LANES-1:0] a1,
                                           input logic [LANES-1:0] a0,
                                           input logic [LANES-1:0] b1,
                                           input logic [LANES-1:0] b0);
        golden_t g;
        g.g0 = a0 & b0;
        g.g1 = (a1 & b0) ^ (a0 & b1);
        g.g2 = a1 & b1 & ~(a0 & b0);
        g.g3 = a1 & a0 & b1 & b0;
        return g;
    endfunction

endpackage

// File: rtl/mul4_fitness_scorer_popcount16.sv
// Combinational population count of a 16-bit vector.
module popcount16 (
    input  logic [15:0] din,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(din[i]);
        end
    end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Scores an evolved 2x2 multiplier: counts correct output bits against the golden
// product over NUM_BATCHES bit-sliced 16-lane words, with a two-stage datapath.
module mul4_fitness_scorer
    import mul4_eval_pkg::*;
#(
    parameter int NUM_BATCHES = 4,
    parameter int SCORE_W     = $clog2(64*NUM_BATCHES+1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        a1,
    input  logic [15:0]        a0,
    input  logic [15:0]        b1,
    input  logic [15:0]        b0,
    input  logic [15:0]        y3,
    input  logic [15:0]        y2,
    input  logic [15:0]        y1,
    input  logic [15:0]        y0,
    output logic               result_valid,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] err_y3,
    output logic [SCORE_W-1:0] err_y2,
    output logic [SCORE_W-1:0] err_y1,
    output logic [SCORE_W-1:0] err_y0,
    output logic               perfect
);

    localparam int                 CNT_W = $clog2(NUM_BATCHES+1);
    localparam logic [SCORE_W-1:0] FULL  = SCORE_W'(64*NUM_BATCHES);

    state_t           state;
    logic [CNT_W-1:0] batch_cnt;
    logic             xfer;
    logic             last_xfer;
    logic             clr;
    golden_t          gold;

    logic [LANES-1:0] m3_p1, m2_p1, m1_p1, m0_p1;
    logic             vld_p1;
    logic             vld_p2;
    logic [4:0]       pc3, pc2, pc1, pc0;
    logic [6:0]       wrong_sum;
    logic [6:0]       right_cnt;

    assign xfer      = (state == RUN) && in_valid && in_ready;
    assign last_xfer = xfer && (batch_cnt == CNT_W'(NUM_BATCHES-1));
    assign clr       = start && ((state == IDLE) || (state == DONE));
    assign gold      = golden_2x2(a1, a0, b1, b0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            batch_cnt    <= '0;
            in_ready     <= 1'b0;
            result_valid <= 1'b0;
            perfect      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        batch_cnt <= '0;
                        in_ready  <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        batch_cnt <= batch_cnt + 1'b1;
                        if (last_xfer) begin
                            in_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Accumulators are final once neither stage holds a word.
                    if (!vld_p1 && !vld_p2) begin
                        result_valid <= 1'b1;
                        perfect      <= (score == FULL);
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        result_valid <= 1'b0;
                        perfect      <= 1'b0;
                        batch_cnt    <= '0;
                        in_ready     <= 1'b1;
                        state        <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: per-lane mismatch vectors
    always_ff @(posedge clk) begin
        if (xfer) begin
            m3_p1 <= y3 ^ gold.g3;
            m2_p1 <= y2 ^ gold.g2;
            m1_p1 <= y1 ^ gold.g1;
            m0_p1 <= y0 ^ gold.g0;
        end
    end

    popcount16 u_pc3 (.din(m3_p1), .cnt(pc3));
    popcount16 u_pc2 (.din(m2_p1), .cnt(pc2));
    popcount16 u_pc1 (.din(m1_p1), .cnt(pc1));
    popcount16 u_pc0 (.din(m0_p1), .cnt(pc0));

    assign wrong_sum = 7'(pc3) + 7'(pc2) + 7'(pc1) + 7'(pc0);
    assign right_cnt = 7'd64 - wrong_sum;

    // Stage 2: accumulate error and correct-bit counts
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            score  <= '0;
            err_y3 <= '0;
            err_y2 <= '0;
            err_y1 <= '0;
            err_y0 <= '0;
        end else begin
            vld_p1 <= xfer;
            vld_p2 <= vld_p1;
            if (clr) begin
                score  <= '0;
                err_y3 <= '0;
                err_y2 <= '0;
                err_y1 <= '0;
                err_y0 <= '0;
            end else if (vld_p1) begin
                score  <= score  + SCORE_W'(right_cnt);
                err_y3 <= err_y3 + SCORE_W'(pc3);
                err_y2 <= err_y2 + SCORE_W'(pc2);
                err_y1 <= err_y1 + SCORE_W'(pc1);
                err_y0 <= err_y0 + SCORE_W'(pc0);
            end
        end
    end

endmodule
